// File: rtl/uart_latency_pkg.sv
// Shared types and constants for the button-press latency responder.
package uart_latency_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, WAIT_RESULT} state_t;

  localparam logic [7:0] TRIG_BYTE = 8'h88;
  localparam logic [7:0] ACK_BYTE  = 8'h55;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 300000;

  // Width of the timeout down-counter; it only ever holds TIMEOUT_CYC-1 .. 0.
  function automatic int unsigned timeout_cnt_w(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_latency_responder_if.sv
// Status/register-block side of the latency responder.
interface uart_latency_responder_if;

  logic        en;
  logic [15:0] resp_delay;
  logic        ack_sent;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_timeout;
  logic        busy;
  logic [7:0]  trig_count;
  logic [7:0]  timeout_count;

  modport master (
    output en, resp_delay,
    input  ack_sent, result, result_valid, result_timeout, busy, trig_count, timeout_count
  );

  modport slave (
    input  en, resp_delay,
    output ack_sent, result, result_valid, result_timeout, busy, trig_count, timeout_count
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver; data_valid pulses for one clock when a frame with a good stop bit lands.
module uart_rx #(
  parameter real SYSCLOCK = 100.0,
  parameter real BAUDRATE = 3.0
) (
  input  logic       clk_100mhz,
  input  logic       rst_n_sync,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid
);

  localparam int unsigned ClksPerBit = $rtoi(SYSCLOCK / BAUDRATE + 0.5);
  localparam int unsigned Half       = ClksPerBit / 2 - 1;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

  rx_state_t       st_q;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;

  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      st_q       <= RxIdle;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      data_valid <= 1'b0;
      unique case (st_q)
        RxIdle: begin
          if (!sync_q[1]) begin
            st_q  <= RxStart;
            cnt_q <= CntW'(Half);
          end
        end
        RxStart: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (!sync_q[1]) begin
            st_q  <= RxData;
            cnt_q <= CntW'(ClksPerBit - 1);
            bit_q <= '0;
          end else begin
            st_q <= RxIdle;  // glitch, not a start bit
          end
        end
        RxData: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            shift_q <= {sync_q[1], shift_q[7:1]};
            cnt_q   <= CntW'(ClksPerBit - 1);
            if (bit_q == 3'd7) st_q <= RxStop;
            else               bit_q <= bit_q + 3'd1;
          end
        end
        RxStop: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            if (sync_q[1]) begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
            end
            st_q <= RxIdle;
          end
        end
        default: st_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; send_trig while idle starts a frame, otherwise it is ignored.
module uart_tx #(
  parameter real SYSCLOCK = 100.0,
  parameter real BAUDRATE = 3.0
) (
  input  logic       clk_100mhz,
  input  logic       rst_n_sync,
  input  logic       send_trig,
  input  logic [7:0] data_in,
  output logic       tx
);

  localparam int unsigned ClksPerBit = $rtoi(SYSCLOCK / BAUDRATE + 0.5);
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);

  logic [9:0]      frame_q;
  logic [3:0]      nbits_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      frame_q <= '1;
      nbits_q <= '0;
      cnt_q   <= '0;
      tx      <= 1'b1;
    end else if (nbits_q == '0) begin
      tx <= 1'b1;
      if (send_trig) begin
        frame_q <= {1'b1, data_in, 1'b0};
        nbits_q <= 4'd10;
        cnt_q   <= CntW'(ClksPerBit - 1);
        tx      <= 1'b0;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end else begin
      frame_q <= {1'b1, frame_q[9:1]};
      nbits_q <= nbits_q - 4'd1;
      cnt_q   <= CntW'(ClksPerBit - 1);
      tx      <= (nbits_q == 4'd1) ? 1'b1 : frame_q[1];
    end
  end

endmodule

// File: rtl/uart_latency_responder.sv
// Far-end latency responder: acks a trigger byte after resp_delay clocks, then captures the
// latency byte the initiator returns (or flags a timeout).
module uart_latency_responder
  import uart_latency_pkg::*;
#(
  parameter real         SYSCLOCK    = 100.0,
  parameter real         BAUDRATE    = 3.0,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk_100mhz,
  input  logic rst_n_sync,
  input  logic uart_rx,
  output logic uart_tx,
  uart_latency_responder_if.slave bus
);

  localparam int unsigned      TcntW    = timeout_cnt_w(TIMEOUT_CYC);
  localparam logic [TcntW-1:0] TcntLoad = TcntW'(TIMEOUT_CYC - 1);

  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_trig;

  state_t           state_q;
  logic [15:0]      delay_cnt_q;
  logic [TcntW-1:0] tcnt_q;
  logic             ack_sent_q;
  logic             result_valid_q;
  logic             result_timeout_q;
  logic             busy_q;
  logic [7:0]       result_q;
  logic [7:0]       trig_count_q;
  logic [7:0]       timeout_count_q;

  uart_rx #(
    .SYSCLOCK(SYSCLOCK),
    .BAUDRATE(BAUDRATE)
  ) u_uart_rx (
    .clk_100mhz(clk_100mhz),
    .rst_n_sync(rst_n_sync),
    .rx        (uart_rx),
    .data_out  (rx_data),
    .data_valid(rx_data_valid)
  );

  uart_tx #(
    .SYSCLOCK(SYSCLOCK),
    .BAUDRATE(BAUDRATE)
  ) u_uart_tx (
    .clk_100mhz(clk_100mhz),
    .rst_n_sync(rst_n_sync),
    .send_trig (ack_sent_q),
    .data_in   (ACK_BYTE),
    .tx        (uart_tx)
  );

  assign rx_trig = rx_data_valid && (rx_data == TRIG_BYTE);

  always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q          <= IDLE;
      delay_cnt_q      <= '0;
      tcnt_q           <= '0;
      ack_sent_q       <= 1'b0;
      result_valid_q   <= 1'b0;
      result_timeout_q <= 1'b0;
      busy_q           <= 1'b0;
      result_q         <= '0;
      trig_count_q     <= '0;
      timeout_count_q  <= '0;
    end else begin
      ack_sent_q       <= 1'b0;
      result_valid_q   <= 1'b0;
      result_timeout_q <= 1'b0;
      if (!bus.en) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rx_trig) begin
              delay_cnt_q  <= bus.resp_delay;
              trig_count_q <= sat_inc8(trig_count_q);
              state_q      <= DELAY;
              busy_q       <= 1'b1;
            end
          end
          DELAY: begin
            // A repeated trigger restarts the delay, even on the clock the ack would go out.
            if (rx_trig) begin
              delay_cnt_q  <= bus.resp_delay;
              trig_count_q <= sat_inc8(trig_count_q);
            end else if (delay_cnt_q == '0) begin
              ack_sent_q <= 1'b1;
              tcnt_q     <= TcntLoad;
              state_q    <= WAIT_RESULT;
            end else begin
              delay_cnt_q <= delay_cnt_q - 16'd1;
            end
          end
          WAIT_RESULT: begin
            // Any byte is the result, and it beats a same-cycle timeout.
            if (rx_data_valid) begin
              result_q       <= rx_data;
              result_valid_q <= 1'b1;
              state_q        <= IDLE;
              busy_q         <= 1'b0;
            end else if (tcnt_q == '0) begin
              result_timeout_q <= 1'b1;
              timeout_count_q  <= sat_inc8(timeout_count_q);
              state_q          <= IDLE;
              busy_q           <= 1'b0;
            end else begin
              tcnt_q <= tcnt_q - TcntW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ack_sent       = ack_sent_q;
  assign bus.result         = result_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_timeout = result_timeout_q;
  assign bus.busy           = busy_q;
  assign bus.trig_count     = trig_count_q;
  assign bus.timeout_count  = timeout_count_q;

endmodule
